multicycle_control: RTL and testbench

- Five-state multicycle control FSM for the RV32 subset core; sits directly upstream of the datapath.
- Latches the fetched instruction, decodes it and sequences the datapath control strobes (loadPC, PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl) plus the data-memory read/write strobes.
- Keeps a retired-instruction counter.

---
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Five-state multicycle control FSM (IF/ID/EX/MEM/WB) for the RV32 subset core.
// Optional MEM_WAIT_EN: loads/stores hold in MEM until dAck is sampled high.
module multicycle_control #(
   parameter logic [6:0] SW        = 7'b0100011,
   parameter logic [6:0] LW        = 7'b0000011,
   parameter logic [6:0] IMMEDIATE = 7'b0010011,
   parameter logic [6:0] BEQ       = 7'b1100011,
   parameter logic [6:0] RR        = 7'b0110011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        Zero,
   input  logic        dAck,
   output logic        loadPC,
   output logic        PCSrc,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [3:0]  ALUCtrl,
   output logic        Illegal,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      ST_IF  = 3'd0,
      ST_ID  = 3'd1,
      ST_EX  = 3'd2,
      ST_MEM = 3'd3,
      ST_WB  = 3'd4
   } state_t;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1011;
   localparam logic [3:0] ALU_XOR  = 4'b1101;

   state_t      state;
   state_t      state_next;
   logic [31:0] ir;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_b5;
   logic        is_rr;
   logic        is_imm;
   logic        is_lw;
   logic        is_sw;
   logic        is_beq;
   logic        is_legal;
   logic [3:0]  alu_op;

   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign funct7_b5 = ir[30];

   // Register fields and immediates belong to the datapath, not to control.
   logic unused_ir_bits;
   assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

`ifndef MEM_WAIT_EN
   logic unused_dack;
   assign unused_dack = dAck;
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IF;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir <= '0;
      end else if (state == ST_IF) begin
         ir <= instr;
      end
   end

   // Counts on the same WB->IF edge at which loadPC moves the PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret <= '0;
      end else if (state == ST_WB) begin
         instret <= instret + 32'd1;
      end
   end

   // ---------------- decode ----------------
   always_comb begin
      is_rr    = (opcode == RR);
      is_imm   = (opcode == IMMEDIATE);
      is_lw    = (opcode == LW);
      is_sw    = (opcode == SW);
      is_beq   = (opcode == BEQ);
      is_legal = is_rr | is_imm | is_lw | is_sw | is_beq;
   end

   always_comb begin
      alu_op = ALU_ADD;
      if (is_rr || is_imm) begin
         unique case (funct3)
            3'b000: alu_op = (is_rr && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
         endcase
      end else if (is_beq) begin
         alu_op = ALU_SUB;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = ST_IF;
      unique case (state)
         ST_IF:  state_next = ST_ID;
         ST_ID:  state_next = ST_EX;
         ST_EX:  state_next = ST_MEM;
`ifdef MEM_WAIT_EN
         ST_MEM: state_next = ((is_lw || is_sw) && !dAck) ? ST_MEM : ST_WB;
`else
         ST_MEM: state_next = ST_WB;
`endif
         ST_WB:  state_next = ST_IF;
         default: state_next = ST_IF;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      loadPC   = 1'b0;
      PCSrc    = 1'b0;
      RegWrite = 1'b0;
      MemToReg = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Illegal  = 1'b0;
      ALUSrc   = is_imm | is_lw | is_sw;
      ALUCtrl  = alu_op;
      unique case (state)
         ST_MEM: begin
            MemRead  = is_lw;
            MemWrite = is_sw;
         end
         ST_WB: begin
            loadPC   = 1'b1;
            RegWrite = is_rr | is_imm | is_lw;
            MemToReg = is_lw;
            PCSrc    = is_beq & Zero;
            Illegal  = ~is_legal;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a per-instruction
// reference model; honours MEM_WAIT_EN for the expected MEM duration.
module tb_multicycle_control;

   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_RR  = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        Zero;
   logic        dAck;
   logic        loadPC, PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Illegal;
   logic [3:0]  ALUCtrl;
   logic [31:0] instret;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [31:0] ref_instret;

   // funct3-indexed ALU codes: ADD SLL SLT SLTU XOR SRL OR AND
   logic [3:0] f3_table [8] = '{4'b0010, 4'b1001, 4'b0111, 4'b1011,
                                4'b1101, 4'b1000, 4'b0001, 4'b0000};
   logic [6:0] op_table [5] = '{OP_RR, OP_IMM, OP_LW, OP_SW, OP_BEQ};

   multicycle_control #(
      .SW(OP_SW), .LW(OP_LW), .IMMEDIATE(OP_IMM), .BEQ(OP_BEQ), .RR(OP_RR)
   ) dut (
      .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dAck(dAck),
      .loadPC(loadPC), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
      .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite),
      .ALUCtrl(ALUCtrl), .Illegal(Illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_alu(input logic [31:0] w);
      logic [2:0] f3;
      f3 = w[14:12];
      if (w[6:0] == OP_RR || w[6:0] == OP_IMM) begin
         if (f3 == 3'd5 && w[30]) return 4'b1010;
         if (f3 == 3'd0 && w[30] && w[6:0] == OP_RR) return 4'b0110;
         return f3_table[f3];
      end
      if (w[6:0] == OP_BEQ) return 4'b0110;
      return 4'b0010;
   endfunction

   function automatic logic is_op(input logic [31:0] w, input logic [6:0] op);
      return w[6:0] == op;
   endfunction

   function automatic logic [31:0] strobes();
      return 32'({loadPC, PCSrc, RegWrite, MemToReg, MemRead, MemWrite, Illegal});
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Entered and left at a negedge with the DUT in IF.
   task automatic run_instr(input logic [31:0] w, input logic z, input int unsigned waits);
      logic        mem_op;
      logic        legal;
      int unsigned mem_cycles;
      mem_op = is_op(w, OP_LW) || is_op(w, OP_SW);
      legal  = mem_op || is_op(w, OP_RR) || is_op(w, OP_IMM) || is_op(w, OP_BEQ);
`ifdef MEM_WAIT_EN
      mem_cycles = mem_op ? waits + 1 : 1;
`else
      mem_cycles = 1;
`endif
      rst = 1'b0; instr = w; dAck = 1'b0; Zero = 1'($urandom);
      check_val("if_strobes", strobes(), 32'd0);
      next_cycle();
      instr = $urandom;
      for (int ph = 0; ph < 2; ph++) begin
         check_val("idex_strobes", strobes(), 32'd0);
         check_val("idex_aluctrl", 32'(ALUCtrl), 32'(ref_alu(w)));
         check_val("idex_alusrc", 32'(ALUSrc), 32'(is_op(w, OP_IMM) || mem_op));
         next_cycle();
      end
      for (int unsigned i = 0; i < mem_cycles; i++) begin
`ifdef MEM_WAIT_EN
         dAck = mem_op ? (i == mem_cycles - 1) : 1'($urandom);
`else
         dAck = 1'($urandom);
`endif
         check_val("mem_read", 32'(MemRead), 32'(is_op(w, OP_LW)));
         check_val("mem_write", 32'(MemWrite), 32'(is_op(w, OP_SW)));
         check_val("mem_other", 32'({loadPC, PCSrc, RegWrite, MemToReg, Illegal}), 32'd0);
         next_cycle();
      end
      dAck = 1'b0; Zero = z;
      #1;
      check_val("wb_loadpc", 32'(loadPC), 32'd1);
      check_val("wb_pcsrc", 32'(PCSrc), 32'(is_op(w, OP_BEQ) && z));
      check_val("wb_regwrite", 32'(RegWrite), 32'(is_op(w, OP_RR) || is_op(w, OP_IMM) || is_op(w, OP_LW)));
      check_val("wb_memtoreg", 32'(MemToReg), 32'(is_op(w, OP_LW)));
      check_val("wb_mem_off", 32'({MemRead, MemWrite}), 32'd0);
      check_val("wb_illegal", 32'(Illegal), 32'(!legal));
      check_val("wb_aluctrl", 32'(ALUCtrl), 32'(ref_alu(w)));
      Zero = ~z;
      #1;
      check_val("wb_pcsrc_comb", 32'(PCSrc), 32'(is_op(w, OP_BEQ) && !z));
      Zero = z;
      next_cycle();
      ref_instret = ref_instret + 32'd1;
      check_val("instret", instret, ref_instret);
      check_val("after_wb_strobes", strobes(), 32'd0);
   endtask

   initial begin
      logic [31:0] w;
      rst = 1'b1; instr = '0; Zero = 1'b0; dAck = 1'b0;
      ref_instret = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val("rst_strobes", strobes(), 32'd0);
      check_val("rst_aluctrl", 32'(ALUCtrl), 32'h2);
      check_val("rst_alusrc", 32'(ALUSrc), 32'd0);
      check_val("rst_instret", instret, 32'd0);

      run_instr(32'h002081B3, 1'b1, 0);   // ADD
      run_instr(32'h402081B3, 1'b0, 0);   // SUB
      run_instr(32'h4020D193, 1'b1, 0);   // SRAI
      run_instr(32'h00208463, 1'b1, 0);   // BEQ taken
      run_instr(32'h00208463, 1'b0, 0);   // BEQ not taken
      run_instr(32'h0000A183, 1'b0, 3);   // LW, 3 wait states when enabled
      run_instr(32'h0020A023, 1'b1, 2);   // SW
      run_instr(32'h0000007F, 1'b1, 0);   // unsupported opcode

      // instret wrap
      force dut.instret = 32'hFFFF_FFFF;
      #1;
      release dut.instret;
      #1;
      ref_instret = 32'hFFFF_FFFF;
      check_val("instret_forced", instret, 32'hFFFF_FFFF);
      run_instr(32'h002081B3, 1'b0, 0);

      // reset during EX abandons the instruction
      instr = 32'h002081B3;
      next_cycle();
      instr = $urandom;
      next_cycle();
      check_val("ex_before_rst", strobes(), 32'd0);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      ref_instret = '0;
      check_val("rst_ex_instret", instret, 32'd0);
      check_val("rst_ex_strobes", strobes(), 32'd0);
      check_val("rst_ex_aluctrl", 32'(ALUCtrl), 32'h2);
      run_instr(32'h0000A183, 1'b1, 1);

      for (int n = 0; n < 200; n++) begin
         int unsigned sel;
         sel = $urandom_range(0, 6);
         w = $urandom;
         if (sel < 5) w[6:0] = op_table[sel];
         run_instr(w, 1'($urandom), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
